// File: rtl/timer_controle.sv
// timer_controle: Moore controller for a cascaded down-counter chain.
// Sequences load, prescaled counting, pause/resume and expiry detection.
// Optional build macro: TIMER_CONTROLE_AUTO_RELOAD_EN
//   defined   -> expiry reloads the chain and resumes counting, done pulses
//   undefined -> expiry parks in DONE with done held until acknowledged
//
// Handshake note: this block has no valid/ready channels. Inputs are plain
// levels sampled on every rising edge. Outputs are registered. loadn is a
// single-cycle low strobe, and en is a single-cycle high pulse.
module timer_controle #(
  parameter  int DIV = 4,
  localparam int PW  = $clog2(DIV) + 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       reload,
  input  logic       zero,
  output logic       loadn,
  output logic       en,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          en_d, loadn_d, done_d;

  assign state = state_q;

  // Next-state, prescaler and output decode; priority reload > zero > stop > start > tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reload) begin
          state_d = S_LOAD;
        end else if (zero || stop) begin
          // Nothing to count, or a pause request overrides start.
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_LOAD: begin
        // The load strobe lasts exactly one cycle regardless of inputs.
`ifdef TIMER_CONTROLE_AUTO_RELOAD_EN
        state_d = S_RUN;
        presc_d = '0;
`else
        state_d = S_IDLE;
`endif
      end
      S_RUN: begin
        if (reload) begin
          state_d = S_LOAD;
        end else if (zero) begin
`ifdef TIMER_CONTROLE_AUTO_RELOAD_EN
          state_d = S_LOAD;
          done_d  = 1'b1;
`else
          state_d = S_DONE;
`endif
        end else if (stop) begin
          // Prescaler is held so the partial step survives the pause.
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          en_d    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (reload) begin
          state_d = S_LOAD;
        end else if (stop) begin
          state_d = S_PAUSE;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (reload) begin
          state_d = S_LOAD;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Unused codes recover to IDLE.
        state_d = S_IDLE;
      end
    endcase
    loadn_d = (state_d != S_LOAD);
`ifndef TIMER_CONTROLE_AUTO_RELOAD_EN
    done_d  = (state_d == S_DONE);
`endif
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      loadn   <= 1'b1;
      en      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      loadn   <= loadn_d;
      en      <= en_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_timer_controle.sv
// Testbench for timer_controle (default build, DIV=4).
module tb_timer_controle;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       reload = 1'b0;
  logic       zero = 1'b0;
  logic       loadn;
  logic       en;
  logic       done;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode name plus count of RUN ticks since entry from IDLE.
  int m_mode = 0;   // 0 idle, 1 load, 2 run, 3 pause, 4 done
  int m_prog = 0;
  logic m_en = 1'b0;
  logic prev_en = 1'b0;

  timer_controle #(.DIV(DIV)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .reload(reload),
    .zero(zero), .loadn(loadn), .en(en), .done(done), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_edge(input logic c, input logic sa, input logic so,
                            input logic rl, input logic z);
    m_en = 1'b0;
    if (c) begin
      m_mode = 0;
      m_prog = 0;
    end else begin
      case (m_mode)
        0: if (rl) m_mode = 1;
           else if (sa && !so && !z) begin m_mode = 2; m_prog = 0; end
        1: m_mode = 0;
        2: if (rl) m_mode = 1;
           else if (z) m_mode = 4;
           else if (so) m_mode = 3;
           else begin
             m_prog = m_prog + 1;
             m_en = ((m_prog % DIV) == 0);
           end
        3: if (rl) m_mode = 1;
           else if (sa && !so) m_mode = 2;
        4: if (rl) m_mode = 1;
           else if (so) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  // Driver: apply inputs for one cycle, advance model, check after the edge.
  task automatic step(input logic c, input logic sa, input logic so,
                      input logic rl, input logic z);
    @(negedge clk);
    clr = c; start = sa; stop = so; reload = rl; zero = z;
    @(posedge clk);
    model_edge(c, sa, so, rl, z);
    #1;
    n_checks++;
    assert (state === 3'(m_mode)) else begin
      n_fail++;
      $error("FAIL state observed=%0d expected=%0d t=%0t", state, m_mode, $time);
    end
    check_bit("loadn", loadn, (m_mode != 1));
    check_bit("en", en, m_en);
    check_bit("done", done, (m_mode == 4));
    if (DIV > 1) check_bit("en_not_back_to_back", en && prev_en, 1'b0);
    if (!loadn) check_bit("en_with_loadn", en, 1'b0);
    prev_en = en;
  endtask

  task automatic idle_steps(input int n, input logic z);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, z);
  endtask

  initial begin
    // Reset for two edges
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    // Reload from IDLE: one-cycle load strobe
    step(1'b0, 1'b0, 0, 1, 0);
    idle_steps(2, 1'b0);
    // Start and count through three en pulses
    step(1'b0, 1'b1, 0, 0, 0);
    idle_steps(13, 1'b0);
    // Stop two cycles after a pulse, then resume
    step(1'b0, 1'b0, 1, 0, 0);
    idle_steps(3, 1'b0);
    step(1'b0, 1'b1, 1, 0, 0);
    step(1'b0, 1'b1, 0, 0, 0);
    idle_steps(5, 1'b0);
    // Expiry, then acknowledge with zero still high
    step(1'b0, 1'b0, 0, 0, 1);
    step(1'b0, 1'b1, 0, 0, 1);
    step(1'b0, 1'b0, 1, 0, 1);
    // Start with zero high stays in IDLE
    step(1'b0, 1'b1, 0, 0, 1);
    // Reload and stop together in RUN
    step(1'b0, 1'b1, 0, 0, 0);
    idle_steps(2, 1'b0);
    step(1'b0, 1'b0, 1, 1, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    // Reset during the load cycle
    step(1'b0, 1'b0, 0, 1, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 8));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
